// File: rtl/sram_arbiter_pkg.sv
// Shared defaults, FSM encoding and helpers for the buffer SRAM arbiter.
package sram_arbiter_pkg;

  localparam int unsigned DEF_N_REQ        = 4;
  localparam int unsigned DEF_DATA_WIDTH   = 32;
  localparam int unsigned DEF_N_ENTRIES    = 1024;
  localparam int unsigned DEF_DATA_WIDTH_O = 64;
  localparam int unsigned DEF_MAX_BURST    = 8;

  typedef enum logic {
    ST_ARB    = 1'b0,
    ST_LOCKED = 1'b1
  } arb_state_e;

  // Round-robin successor of idx among n requesters.
  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/sram_arbiter_rr_pick.sv
// Round-robin priority selector: first set bit of valid at or after ptr, wrapping at N_REQ-1.
module sram_arbiter_rr_pick #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned IW    = 2
) (
  input  logic [N_REQ-1:0] valid,
  input  logic [IW-1:0]    ptr,
  output logic [N_REQ-1:0] grant,
  output logic [IW-1:0]    idx,
  output logic             any
);

  always_comb begin
    int unsigned k;
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    k     = 0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      k = (32'(ptr) + i) % N_REQ;
      if (!any && valid[k]) begin
        any      = 1'b1;
        grant[k] = 1'b1;
        idx      = IW'(k);
      end
    end
  end

endmodule

// File: rtl/sram_arbiter.sv
// N-way round-robin arbiter for one single-port buffer SRAM with bounded burst lock,
// out-of-range read blocking and a one-cycle read response path.
//
// state     | meaning
// ST_ARB    | round-robin grant from rr_ptr each cycle
// ST_LOCKED | owner holds the grant while valid & lock, up to MAX_BURST beats
module sram_arbiter
  import sram_arbiter_pkg::*;
#(
  parameter int unsigned N_REQ        = DEF_N_REQ,
  parameter int unsigned DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int unsigned N_ENTRIES    = DEF_N_ENTRIES,
  parameter int unsigned DATA_WIDTH_O = DEF_DATA_WIDTH_O,
  parameter int unsigned MAX_BURST    = DEF_MAX_BURST,
  localparam int unsigned AW          = $clog2(N_ENTRIES),
  localparam int unsigned IW          = $clog2(N_REQ)
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic [N_REQ-1:0]            req_valid_i,
  output logic [N_REQ-1:0]            req_ready_o,
  input  logic [N_REQ-1:0]            req_we_i,
  input  logic [N_REQ-1:0]            req_lock_i,
  input  logic [N_REQ*AW-1:0]         req_addr_i,
  input  logic [N_REQ*DATA_WIDTH-1:0] req_wdata_i,
  output logic [N_REQ-1:0]            rsp_valid_o,
  output logic [DATA_WIDTH_O-1:0]     rsp_rdata_o,
  output logic                        rsp_err_o,
  output logic                        sram_en_o,
  output logic                        sram_we_o,
  output logic [AW-1:0]               sram_addr_o,
  output logic [DATA_WIDTH-1:0]       sram_wdata_o,
  input  logic [DATA_WIDTH_O-1:0]     sram_rdata_i
);

  localparam int unsigned WORDS = DATA_WIDTH_O / DATA_WIDTH;
  localparam int unsigned CW    = $clog2(MAX_BURST + 1);
  localparam logic [AW:0]   LAST_START = (AW + 1)'(N_ENTRIES - WORDS);
  localparam logic [CW-1:0] BURST_MAX  = CW'(MAX_BURST);

  arb_state_e      state_q, state_d;
  logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]   owner_q, owner_d;
  logic [CW-1:0]   burst_cnt_q, burst_cnt_d;

  logic [N_REQ-1:0] pick_grant;
  logic [IW-1:0]    pick_idx;
  logic             pick_any;
  logic             hold_lock;
  logic [N_REQ-1:0] grant;
  logic [IW-1:0]    gnt_idx;
  logic             hs;

  logic                  g_we;
  logic                  g_lock;
  logic [AW-1:0]         g_addr;
  logic [DATA_WIDTH-1:0] g_wdata;
  logic                  bad;

  logic          rsp_vld_q;
  logic          rsp_err_q;
  logic [IW-1:0] rsp_id_q;

  sram_arbiter_rr_pick #(
    .N_REQ (N_REQ),
    .IW    (IW)
  ) u_rr_pick (
    .valid (req_valid_i),
    .ptr   (rr_ptr_q),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  // Once the lock condition fails, the same cycle falls back to plain round-robin.
  assign hold_lock = (state_q == ST_LOCKED) && req_valid_i[owner_q] &&
                     req_lock_i[owner_q] && (burst_cnt_q != BURST_MAX);

  always_comb begin
    grant   = '0;
    gnt_idx = pick_idx;
    if (hold_lock) begin
      grant[owner_q] = 1'b1;
      gnt_idx        = owner_q;
    end else if (pick_any) begin
      grant = pick_grant;
    end
    if (!rst_ni) begin
      grant = '0;
    end
  end

  assign req_ready_o = grant;
  assign hs          = |grant;

  assign g_we    = req_we_i[gnt_idx];
  assign g_lock  = req_lock_i[gnt_idx];
  assign g_addr  = req_addr_i[32'(gnt_idx) * AW +: AW];
  assign g_wdata = req_wdata_i[32'(gnt_idx) * DATA_WIDTH +: DATA_WIDTH];

  // A read window must fit entirely inside the array.
  assign bad = hs && !g_we && ({1'b0, g_addr} > LAST_START);

  assign sram_en_o    = hs && !bad;
  assign sram_we_o    = hs && g_we;
  assign sram_addr_o  = hs ? g_addr  : '0;
  assign sram_wdata_o = hs ? g_wdata : '0;

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    owner_d     = owner_q;
    burst_cnt_d = burst_cnt_q;
    if (hold_lock) begin
      burst_cnt_d = burst_cnt_q + CW'(1);
      rr_ptr_d    = IW'(rr_next(32'(owner_q), N_REQ));
    end else begin
      state_d     = ST_ARB;
      burst_cnt_d = '0;
      if (hs) begin
        rr_ptr_d = IW'(rr_next(32'(pick_idx), N_REQ));
        if (g_lock) begin
          state_d     = ST_LOCKED;
          owner_d     = pick_idx;
          burst_cnt_d = CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_ARB;
      rr_ptr_q    <= '0;
      owner_q     <= '0;
      burst_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      owner_q     <= owner_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rsp_vld_q <= 1'b0;
      rsp_err_q <= 1'b0;
      rsp_id_q  <= '0;
    end else begin
      rsp_vld_q <= hs && !g_we;
      rsp_err_q <= bad;
      rsp_id_q  <= gnt_idx;
    end
  end

  always_comb begin
    rsp_valid_o = '0;
    if (rsp_vld_q) begin
      rsp_valid_o[rsp_id_q] = 1'b1;
    end
  end

  assign rsp_err_o   = rsp_vld_q && rsp_err_q;
  assign rsp_rdata_o = (rsp_vld_q && !rsp_err_q) ? sram_rdata_i : '0;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed and random checks for sram_arbiter with a behavioural SRAM and shadow memory.
module tb_sram_arbiter;

  logic         clk_i = 1'b0;
  logic         rst_ni;
  logic [3:0]   req_valid;
  logic [3:0]   req_ready_o;
  logic [3:0]   req_we;
  logic [3:0]   req_lock;
  logic [39:0]  req_addr;
  logic [127:0] req_wdata;
  logic [3:0]   rsp_valid_o;
  logic [63:0]  rsp_rdata_o;
  logic         rsp_err_o;
  logic         sram_en_o;
  logic         sram_we_o;
  logic [9:0]   sram_addr_o;
  logic [31:0]  sram_wdata_o;
  logic [63:0]  sram_rdata_i;

  int pass_cnt = 0;
  int total_cnt = 0;

  logic [31:0] mem     [0:1023];
  logic [31:0] exp_mem [0:1023];
  logic        mem_inited = 1'b0;

  always #5 clk_i = ~clk_i;

  sram_arbiter dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready_o),
    .req_we_i     (req_we),
    .req_lock_i   (req_lock),
    .req_addr_i   (req_addr),
    .req_wdata_i  (req_wdata),
    .rsp_valid_o  (rsp_valid_o),
    .rsp_rdata_o  (rsp_rdata_o),
    .rsp_err_o    (rsp_err_o),
    .sram_en_o    (sram_en_o),
    .sram_we_o    (sram_we_o),
    .sram_addr_o  (sram_addr_o),
    .sram_wdata_o (sram_wdata_o),
    .sram_rdata_i (sram_rdata_i)
  );

  function automatic logic [31:0] pat(input int i);
    return 32'hC0DE_0000 | 32'(i);
  endfunction

  // Behavioural SRAM: registered two-word read, one-word write.
  always @(posedge clk_i) begin
    if (!mem_inited) begin
      for (int i = 0; i < 1024; i++) mem[i] <= pat(i);
      mem_inited <= 1'b1;
    end else if (sram_en_o) begin
      if (sram_we_o) mem[sram_addr_o] <= sram_wdata_o;
      else sram_rdata_i <= {mem[sram_addr_o + 10'd1], mem[sram_addr_o]};
    end
  end

  function automatic logic [63:0] exp_rd(input logic [9:0] a);
    logic [9:0] a1;
    a1 = a + 10'd1;
    return {exp_mem[a1], exp_mem[a]};
  endfunction

  task automatic set_req(input int k, input logic v, input logic we, input logic lk,
                         input int unsigned a, input logic [31:0] d);
    req_valid[k]           = v;
    req_we[k]              = we;
    req_lock[k]            = lk;
    req_addr[k*10 +: 10]   = 10'(a);
    req_wdata[k*32 +: 32]  = d;
  endtask

  task automatic clear_reqs();
    req_valid = '0;
    req_we    = '0;
    req_lock  = '0;
  endtask

  task automatic test_reset();
    rst_ni    = 1'b0;
    req_valid = 4'hF;
    req_we    = 4'h0;
    req_lock  = 4'hF;
    req_addr  = '0;
    req_wdata = '0;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    total_cnt++;
    if (req_ready_o !== 4'b0) $display("FAIL reset_ready: got %b want 0000", req_ready_o);
    else pass_cnt++;
    total_cnt++;
    if ({sram_en_o, sram_we_o, sram_addr_o, sram_wdata_o} !== '0)
      $display("FAIL reset_sram: got en=%b we=%b addr=%0d wdata=%h want all 0",
               sram_en_o, sram_we_o, sram_addr_o, sram_wdata_o);
    else pass_cnt++;
    total_cnt++;
    if ({rsp_valid_o, rsp_err_o, rsp_rdata_o} !== '0)
      $display("FAIL reset_rsp: got valid=%b err=%b rdata=%h want all 0",
               rsp_valid_o, rsp_err_o, rsp_rdata_o);
    else pass_cnt++;
    clear_reqs();
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
  endtask

  task automatic test_rr_reads();
    for (int k = 0; k < 4; k++) set_req(k, 1'b1, 1'b0, 1'b0, 2 * k, 32'h0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk_i);
      total_cnt++;
      if (req_ready_o !== 4'(1 << k)) $display("FAIL rr_grant%0d: got %b want %b", k, req_ready_o, 4'(1 << k));
      else pass_cnt++;
      total_cnt++;
      if ({sram_en_o, sram_we_o, sram_addr_o} !== {1'b1, 1'b0, 10'(2 * k)})
        $display("FAIL rr_sram%0d: got en=%b we=%b addr=%0d want en=1 we=0 addr=%0d", k, sram_en_o, sram_we_o, sram_addr_o, 2 * k);
      else pass_cnt++;
      if (k > 0) begin
        total_cnt++;
        if (rsp_valid_o !== 4'(1 << (k - 1))) $display("FAIL rr_rsp_valid%0d: got %b want %b", k - 1, rsp_valid_o, 4'(1 << (k - 1)));
        else pass_cnt++;
        total_cnt++;
        if (rsp_rdata_o !== exp_rd(10'(2 * (k - 1)))) $display("FAIL rr_rsp_data%0d: got %h want %h", k - 1, rsp_rdata_o, exp_rd(10'(2 * (k - 1))));
        else pass_cnt++;
      end
      @(posedge clk_i); #1;
      req_valid[k] = 1'b0;
    end
    @(negedge clk_i);
    total_cnt++;
    if ({rsp_valid_o, rsp_err_o, rsp_rdata_o} !== {4'b1000, 1'b0, exp_rd(10'd6)})
      $display("FAIL rr_rsp3: got valid=%b err=%b data=%h want 1000 0 %h", rsp_valid_o, rsp_err_o, rsp_rdata_o, exp_rd(10'd6));
    else pass_cnt++;
    @(posedge clk_i); #1;
  endtask

  task automatic test_lock_burst();
    set_req(1, 1'b1, 1'b0, 1'b1, 20, 32'h0);
    @(negedge clk_i);
    total_cnt++;
    if (req_ready_o !== 4'b0010) $display("FAIL lock_first: got %b want 0010", req_ready_o);
    else pass_cnt++;
    @(posedge clk_i); #1;
    set_req(0, 1'b1, 1'b0, 1'b0, 30, 32'h0);
    set_req(2, 1'b1, 1'b0, 1'b0, 40, 32'h0);
    for (int i = 1; i < 8; i++) begin
      @(negedge clk_i);
      total_cnt++;
      if (req_ready_o !== 4'b0010) $display("FAIL lock_beat%0d: got %b want 0010", i, req_ready_o);
      else pass_cnt++;
      if (i == 1) begin
        total_cnt++;
        if ({rsp_valid_o, rsp_rdata_o} !== {4'b0010, exp_rd(10'd20)})
          $display("FAIL lock_rsp: got %b %h want 0010 %h", rsp_valid_o, rsp_rdata_o, exp_rd(10'd20));
        else pass_cnt++;
      end
      @(posedge clk_i); #1;
    end
    @(negedge clk_i);
    total_cnt++;
    if (req_ready_o !== 4'b0100) $display("FAIL lock_exit: got %b want 0100", req_ready_o);
    else pass_cnt++;
    @(posedge clk_i); #1;
    req_valid[2] = 1'b0;
    @(negedge clk_i);
    total_cnt++;
    if (req_ready_o !== 4'b0001) $display("FAIL lock_after: got %b want 0001", req_ready_o);
    else pass_cnt++;
    @(posedge clk_i); #1;
    clear_reqs();
  endtask

  task automatic test_bounds();
    set_req(0, 1'b1, 1'b0, 1'b0, 1023, 32'h0);
    @(negedge clk_i);
    total_cnt++;
    if ({req_ready_o, sram_en_o} !== {4'b0001, 1'b0})
      $display("FAIL bad_read_issue: got ready=%b en=%b want 0001 0", req_ready_o, sram_en_o);
    else pass_cnt++;
    @(posedge clk_i); #1;
    set_req(0, 1'b1, 1'b0, 1'b0, 1022, 32'h0);
    @(negedge clk_i);
    total_cnt++;
    if ({rsp_valid_o, rsp_err_o, rsp_rdata_o} !== {4'b0001, 1'b1, 64'h0})
      $display("FAIL bad_read_rsp: got valid=%b err=%b data=%h want 0001 1 0", rsp_valid_o, rsp_err_o, rsp_rdata_o);
    else pass_cnt++;
    total_cnt++;
    if ({sram_en_o, sram_addr_o} !== {1'b1, 10'd1022})
      $display("FAIL edge_read_issue: got en=%b addr=%0d want 1 1022", sram_en_o, sram_addr_o);
    else pass_cnt++;
    @(posedge clk_i); #1;
    req_valid[0] = 1'b0;
    set_req(3, 1'b1, 1'b1, 1'b0, 1023, 32'h1234_5678);
    @(negedge clk_i);
    total_cnt++;
    if ({rsp_valid_o, rsp_err_o, rsp_rdata_o} !== {4'b0001, 1'b0, exp_rd(10'd1022)})
      $display("FAIL edge_read_rsp: got valid=%b err=%b data=%h want 0001 0 %h", rsp_valid_o, rsp_err_o, rsp_rdata_o, exp_rd(10'd1022));
    else pass_cnt++;
    total_cnt++;
    if ({sram_en_o, sram_we_o, sram_addr_o, sram_wdata_o} !== {1'b1, 1'b1, 10'd1023, 32'h1234_5678})
      $display("FAIL edge_write: got en=%b we=%b addr=%0d wdata=%h want 1 1 1023 12345678", sram_en_o, sram_we_o, sram_addr_o, sram_wdata_o);
    else pass_cnt++;
    exp_mem[1023] = 32'h1234_5678;
    @(posedge clk_i); #1;
    clear_reqs();
    @(negedge clk_i);
    total_cnt++;
    if (rsp_valid_o !== 4'b0) $display("FAIL write_no_rsp: got %b want 0000", rsp_valid_o);
    else pass_cnt++;
    @(posedge clk_i); #1;
  endtask

  task automatic test_back_to_back_raw();
    set_req(2, 1'b1, 1'b1, 1'b0, 10, 32'hDEAD_BEEF);
    @(negedge clk_i);
    total_cnt++;
    if ({req_ready_o, sram_en_o, sram_we_o, sram_addr_o, sram_wdata_o} !== {4'b0100, 1'b1, 1'b1, 10'd10, 32'hDEAD_BEEF})
      $display("FAIL raw_write: got ready=%b en=%b we=%b addr=%0d wdata=%h want 0100 1 1 10 deadbeef",
               req_ready_o, sram_en_o, sram_we_o, sram_addr_o, sram_wdata_o);
    else pass_cnt++;
    exp_mem[10] = 32'hDEAD_BEEF;
    @(posedge clk_i); #1;
    set_req(2, 1'b1, 1'b0, 1'b0, 10, 32'h0);
    @(negedge clk_i);
    total_cnt++;
    if ({req_ready_o, rsp_valid_o} !== {4'b0100, 4'b0000})
      $display("FAIL raw_read_issue: got ready=%b rsp=%b want 0100 0000", req_ready_o, rsp_valid_o);
    else pass_cnt++;
    @(posedge clk_i); #1;
    clear_reqs();
    @(negedge clk_i);
    total_cnt++;
    if ({rsp_valid_o, rsp_rdata_o} !== {4'b0100, pat(11), 32'hDEAD_BEEF})
      $display("FAIL raw_read_rsp: got valid=%b data=%h want 0100 %h", rsp_valid_o, rsp_rdata_o, {pat(11), 32'hDEAD_BEEF});
    else pass_cnt++;
    @(posedge clk_i); #1;
  endtask

  task automatic test_reset_mid_burst();
    set_req(3, 1'b1, 1'b0, 1'b1, 50, 32'h0);
    @(negedge clk_i);
    total_cnt++;
    if (req_ready_o !== 4'b1000) $display("FAIL mid_first: got %b want 1000", req_ready_o);
    else pass_cnt++;
    @(posedge clk_i); #1;
    @(negedge clk_i);
    total_cnt++;
    if (req_ready_o !== 4'b1000) $display("FAIL mid_second: got %b want 1000", req_ready_o);
    else pass_cnt++;
    @(posedge clk_i); #1;
    rst_ni = 1'b0;
    set_req(1, 1'b1, 1'b0, 1'b0, 70, 32'h0);
    #1;
    total_cnt++;
    if ({req_ready_o, rsp_valid_o, rsp_err_o, rsp_rdata_o, sram_en_o, sram_addr_o} !== '0)
      $display("FAIL mid_reset_outputs: got ready=%b rsp=%b err=%b data=%h en=%b addr=%0d want all 0",
               req_ready_o, rsp_valid_o, rsp_err_o, rsp_rdata_o, sram_en_o, sram_addr_o);
    else pass_cnt++;
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    @(negedge clk_i);
    total_cnt++;
    if ({req_ready_o, rsp_valid_o} !== {4'b0010, 4'b0000})
      $display("FAIL mid_after_release: got ready=%b rsp=%b want 0010 0000", req_ready_o, rsp_valid_o);
    else pass_cnt++;
    @(posedge clk_i); #1;
    clear_reqs();
    @(negedge clk_i);
    total_cnt++;
    if ({rsp_valid_o, rsp_rdata_o} !== {4'b0010, exp_rd(10'd70)})
      $display("FAIL mid_first_rsp: got %b %h want 0010 %h", rsp_valid_o, rsp_rdata_o, exp_rd(10'd70));
    else pass_cnt++;
    @(posedge clk_i); #1;
  endtask

  task automatic test_random();
    logic        pend;
    logic        pend_err;
    logic [1:0]  pend_id;
    logic [63:0] pend_data;
    logic [3:0]  gnt;
    logic [9:0]  a;
    int          wait_cnt [4];
    int          max_wait;
    pend = 1'b0; pend_err = 1'b0; pend_id = 2'd0; pend_data = '0; max_wait = 0;
    gnt = '0; a = '0;
    for (int k = 0; k < 4; k++) wait_cnt[k] = 0;
    for (int c = 0; c < 600; c++) begin
      for (int k = 0; k < 4; k++) begin
        if (!req_valid[k] && $urandom_range(0, 2) != 0)
          set_req(k, 1'b1, 1'($urandom_range(0, 1)), 1'b0,
                  ($urandom_range(0, 9) == 0) ? 1023 : $urandom_range(0, 15), $urandom());
        req_lock[k] = ($urandom_range(0, 3) != 0);
      end
      @(negedge clk_i);
      gnt = req_ready_o;
      total_cnt++;
      if (rsp_valid_o !== (pend ? 4'(1 << pend_id) : 4'b0))
        $display("FAIL rnd_rsp_valid c%0d: got %b want %b", c, rsp_valid_o, pend ? 4'(1 << pend_id) : 4'b0);
      else pass_cnt++;
      if (pend) begin
        total_cnt++;
        if ({rsp_err_o, rsp_rdata_o} !== {pend_err, pend_err ? 64'h0 : pend_data})
          $display("FAIL rnd_rsp_data c%0d: got err=%b %h want err=%b %h", c, rsp_err_o, rsp_rdata_o,
                   pend_err, pend_err ? 64'h0 : pend_data);
        else pass_cnt++;
      end
      total_cnt++;
      if (((gnt & (gnt - 4'd1)) != 4'd0) || ((gnt & ~req_valid) != 4'd0))
        $display("FAIL rnd_grant c%0d: got %b with valid %b want one-hot subset", c, gnt, req_valid);
      else pass_cnt++;
      pend = 1'b0;
      for (int k = 0; k < 4; k++) begin
        if (gnt[k]) begin
          a = req_addr[k*10 +: 10];
          if (req_we[k]) begin
            exp_mem[a] = req_wdata[k*32 +: 32];
          end else begin
            pend      = 1'b1;
            pend_id   = 2'(k);
            pend_err  = (a > 10'd1022);
            pend_data = exp_rd(a);
          end
        end
        if (req_valid[k] && !gnt[k]) begin
          wait_cnt[k]++;
          if (wait_cnt[k] > max_wait) max_wait = wait_cnt[k];
        end else begin
          wait_cnt[k] = 0;
        end
      end
      @(posedge clk_i); #1;
      req_valid = req_valid & ~gnt;
    end
    clear_reqs();
    @(negedge clk_i);
    total_cnt++;
    if (rsp_valid_o !== (pend ? 4'(1 << pend_id) : 4'b0))
      $display("FAIL rnd_drain: got %b want %b", rsp_valid_o, pend ? 4'(1 << pend_id) : 4'b0);
    else pass_cnt++;
    total_cnt++;
    if (max_wait > 24) $display("FAIL rnd_starvation: got max wait %0d want <= 24", max_wait);
    else pass_cnt++;
    @(posedge clk_i); #1;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) exp_mem[i] = pat(i);
    test_reset();
    test_rr_reads();
    test_lock_burst();
    test_bounds();
    test_back_to_back_raw();
    test_reset_mid_burst();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
